// File: rtl/rat_rename_map.sv
// rat_rename_map: speculative front-end register alias table.
//
// Renames up to SCALAR instructions per cycle. Slot 0 is the oldest slot.
// Each slot gets:
//   - source lookups, with bypass from older slots in the same group;
//   - the previous mapping of its destination, which the ROB frees at retire;
//   - a write of its new destination tag into the map.
// Rollback copies the whole committed map from the retirement RAT. After a
// rollback, rename stays stalled for RECOVER_CYCLES cycles.
//
// Optional feature: define RAT_RECOVER_BYPASS_EN to remove the recovery
// window. Rename then resumes on the cycle right after the restore, and
// RECOVER_CYCLES is ignored.
//
// Ports:
//   clock          in   clock; all state updates on posedge
//   reset          in   synchronous active-low reset
//   rename_en      in   [SCALAR] per-slot rename request
//   src1_areg      in   [SCALAR*A] per-slot source 1 architectural index
//   src2_areg      in   [SCALAR*A] per-slot source 2 architectural index
//   dest_areg      in   [SCALAR*A] per-slot destination architectural index
//   dest_preg      in   [SCALAR*P] per-slot new tag from the freelist
//   rollback_en    in   squash request; restore from rrat_map_in
//   rrat_map_in    in   [NUM_ENTRIES*P] committed map; entry i at [i*P +: P]
//   src1_preg      out  [SCALAR*P] renamed source 1 tag (combinational)
//   src2_preg      out  [SCALAR*P] renamed source 2 tag (combinational)
//   old_dest_preg  out  [SCALAR*P] previous mapping of dest_areg (combinational)
//   rename_stall   out  high while rename requests are being ignored
module rat_rename_map #(
    parameter int SCALAR         = 2,
    parameter int NUM_ENTRIES    = 32,
    parameter int AREG_IDX_WIDTH = 5,
    parameter int PREG_IDX_WIDTH = 6,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [SCALAR-1:0]                   rename_en,
    input  logic [SCALAR*AREG_IDX_WIDTH-1:0]    src1_areg,
    input  logic [SCALAR*AREG_IDX_WIDTH-1:0]    src2_areg,
    input  logic [SCALAR*AREG_IDX_WIDTH-1:0]    dest_areg,
    input  logic [SCALAR*PREG_IDX_WIDTH-1:0]    dest_preg,
    input  logic                                rollback_en,
    input  logic [NUM_ENTRIES*PREG_IDX_WIDTH-1:0] rrat_map_in,
    output logic [SCALAR*PREG_IDX_WIDTH-1:0]    src1_preg,
    output logic [SCALAR*PREG_IDX_WIDTH-1:0]    src2_preg,
    output logic [SCALAR*PREG_IDX_WIDTH-1:0]    old_dest_preg,
    output logic                                rename_stall
);
    localparam int A = AREG_IDX_WIDTH;
    localparam int P = PREG_IDX_WIDTH;

    logic [P-1:0] map_q [NUM_ENTRIES];
    logic         write_ok;  // rename writes are allowed this cycle

`ifdef RAT_RECOVER_BYPASS_EN
    // There is no recovery window. Only the restore cycle itself stalls.
    assign rename_stall = rollback_en;
    assign write_ok     = !rollback_en;
`else
    localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    typedef enum logic {NORMAL, RECOVER} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rename_stall = 1'b0;
        case (state_q)
            NORMAL: begin
                if (rollback_en) begin
                    rename_stall = 1'b1;
                    state_d      = RECOVER;
                    cnt_d        = CW'(RECOVER_CYCLES - 1);
                end
            end
            RECOVER: begin
                rename_stall = 1'b1;
                // A rollback during recovery restarts the window.
                if (rollback_en)
                    cnt_d = CW'(RECOVER_CYCLES - 1);
                else if (cnt_q == '0)
                    state_d = NORMAL;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            default: state_d = NORMAL;
        endcase
    end

    assign write_ok = (state_q == NORMAL) && !rollback_en;
`endif

    // Map storage. Slots are walked oldest to youngest, so when two slots
    // name the same destination, the youngest write lands last.
    // Areg 0 is never written by rename.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                map_q[i] <= P'(i);
        end else if (rollback_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                map_q[i] <= rrat_map_in[i*P +: P];
        end else if (write_ok) begin
            for (int k = 0; k < SCALAR; k++)
                if (rename_en[k] && dest_areg[k*A +: A] != '0)
                    map_q[dest_areg[k*A +: A]] <= dest_preg[k*P +: P];
        end
    end

    // Per-slot lookup with intra-group bypass. Older slots are scanned in
    // ascending order, so the youngest matching older slot overrides the rest.
    for (genvar k = 0; k < SCALAR; k++) begin : g_slot
        logic [A-1:0] s1a, s2a, da;
        logic [P-1:0] p1, p2, pd;

        assign s1a = src1_areg[k*A +: A];
        assign s2a = src2_areg[k*A +: A];
        assign da  = dest_areg[k*A +: A];

        always_comb begin
            p1 = map_q[s1a];
            p2 = map_q[s2a];
            pd = map_q[da];
            for (int j = 0; j < k; j++) begin
                if (rename_en[j] && dest_areg[j*A +: A] != '0) begin
                    if (dest_areg[j*A +: A] == s1a) p1 = dest_preg[j*P +: P];
                    if (dest_areg[j*A +: A] == s2a) p2 = dest_preg[j*P +: P];
                    if (dest_areg[j*A +: A] == da)  pd = dest_preg[j*P +: P];
                end
            end
        end

        assign src1_preg[k*P +: P]     = p1;
        assign src2_preg[k*P +: P]     = p2;
        assign old_dest_preg[k*P +: P] = pd;
    end

endmodule

// File: tb/tb_rat_rename_map.sv
// Testbench for rat_rename_map. The stimulus pushes expected values, each
// tagged with a cycle number, into a queue. A separate monitor pops those
// entries at the negedge of the matching cycle and compares them.
module tb_rat_rename_map;
    localparam int S = 2, N = 32, A = 5, P = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic [S-1:0]     rename_en;
    logic [S*A-1:0]   src1_areg, src2_areg, dest_areg;
    logic [S*P-1:0]   dest_preg;
    logic             rollback_en;
    logic [N*P-1:0]   rrat_map_in;
    logic [S*P-1:0]   src1_preg, src2_preg, old_dest_preg;
    logic             rename_stall;

    rat_rename_map #(.SCALAR(S), .NUM_ENTRIES(N), .AREG_IDX_WIDTH(A),
                     .PREG_IDX_WIDTH(P), .RECOVER_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .rename_en(rename_en),
        .src1_areg(src1_areg), .src2_areg(src2_areg), .dest_areg(dest_areg),
        .dest_preg(dest_preg), .rollback_en(rollback_en), .rrat_map_in(rrat_map_in),
        .src1_preg(src1_preg), .src2_preg(src2_preg), .old_dest_preg(old_dest_preg),
        .rename_stall(rename_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    cyc;
        int    sig;   // 0 src1, 1 src2, 2 old_dest, 3 stall
        int    slot;
        int    exp;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0, n_mis = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int get_out(int sig, int slot);
        case (sig)
            0: return int'(src1_preg[slot*P +: P]);
            1: return int'(src2_preg[slot*P +: P]);
            2: return int'(old_dest_preg[slot*P +: P]);
            default: return int'(rename_stall);
        endcase
    endfunction

    // Monitor: compares every expectation that falls due this cycle. An entry
    // for an earlier cycle means its check window was missed.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   act;
            e = q.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_mis++;
                $display("FAIL %s: check window missed (cycle %0d, now %0d)", e.name, e.cyc, cyc);
            end else begin
                act = get_out(e.sig, e.slot);
                if (act != e.exp) begin
                    n_mis++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.exp, cyc);
                end
            end
        end
    end

    task automatic expect_val(int sig, int slot, int exp, string name);
        exp_t e;
        e.cyc = cyc; e.sig = sig; e.slot = slot; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    // Advance to the next cycle and clear the per-cycle request inputs.
    task automatic step();
        @(posedge clock);
        #1;
        rename_en = '0; rollback_en = 1'b0;
        src1_areg = '0; src2_areg = '0; dest_areg = '0; dest_preg = '0;
    endtask

    task automatic slot_req(int k, int s1, int s2, int d, int dp);
        rename_en[k]         = 1'b1;
        src1_areg[k*A +: A]  = A'(s1);
        src2_areg[k*A +: A]  = A'(s2);
        dest_areg[k*A +: A]  = A'(d);
        dest_preg[k*P +: P]  = P'(dp);
    endtask

    initial begin
        reset = 1'b0; rename_en = '0; rollback_en = 1'b0;
        src1_areg = '0; src2_areg = '0; dest_areg = '0; dest_preg = '0;
        for (int i = 0; i < N; i++) rrat_map_in[i*P +: P] = P'(i + 32);
        step(); step();
        reset = 1'b1;

        // 1: identity map after reset
        step();
        slot_req(0, 5, 31, 0, 0);
        expect_val(0, 0, 5, "reset_src1_a5");
        expect_val(1, 0, 31, "reset_src2_a31");
        expect_val(2, 0, 0, "reset_old_a0");
        expect_val(3, 0, 0, "reset_stall");

        // 2: two independent writes in one group
        step();
        slot_req(0, 0, 0, 3, 40);
        slot_req(1, 3, 1, 4, 41);
        expect_val(2, 0, 3, "t2_old_a3");
        expect_val(0, 1, 40, "t2_bypass_s1_a3");
        expect_val(2, 1, 4, "t2_old_a4");
        step();
        slot_req(0, 3, 4, 0, 0);
        expect_val(0, 0, 40, "t2_map3");
        expect_val(1, 0, 41, "t2_map4");

        // 3: intra-group bypass on a source and on old_dest; the youngest write wins
        step();
        slot_req(0, 1, 2, 7, 50);
        slot_req(1, 7, 3, 7, 51);
        expect_val(2, 0, 7, "t3_old_s0");
        expect_val(0, 1, 50, "t3_bypass_s1");
        expect_val(1, 1, 40, "t3_s1_src2_a3");
        expect_val(2, 1, 50, "t3_bypass_old");
        step();
        slot_req(0, 7, 1, 0, 0);
        expect_val(0, 0, 51, "t3_map7");

        // 4: areg 0 is never written and never bypassed
        step();
        slot_req(0, 0, 0, 0, 60);
        slot_req(1, 0, 0, 0, 0);
        expect_val(0, 1, 0, "t4_no_bypass_a0");
        step();
        slot_req(0, 0, 0, 0, 0);
        expect_val(0, 0, 0, "t4_map0");
        expect_val(2, 0, 0, "t4_old_a0");

        // 5: rollback with a concurrent rename, then the recovery window
        step();
        rollback_en = 1'b1;
        slot_req(0, 0, 0, 2, 45);
        expect_val(3, 0, 1, "t5_stall_rb");
        step();
        slot_req(0, 0, 0, 9, 20);
        expect_val(3, 0, 1, "t5_stall_r1");
        step();
        slot_req(0, 0, 0, 9, 21);
        expect_val(3, 0, 1, "t5_stall_r2");
        step();
        slot_req(0, 2, 9, 3, 22);
        expect_val(3, 0, 0, "t5_stall_done");
        expect_val(0, 0, 34, "t5_map2_restored");
        expect_val(1, 0, 41, "t5_map9_no_write");
        expect_val(2, 0, 35, "t5_old_a3");
        step();
        slot_req(0, 3, 0, 0, 0);
        expect_val(0, 0, 22, "t5_resume_write");

        // 6: reset during recovery restores identity and NORMAL
        step();
        rollback_en = 1'b1;
        expect_val(3, 0, 1, "t6_stall_rb");
        step();
        expect_val(3, 0, 1, "t6_stall_recover");
        reset = 1'b0;
        step();
        reset = 1'b1;
        slot_req(0, 2, 7, 0, 0);
        expect_val(3, 0, 0, "t6_stall_after_reset");
        expect_val(0, 0, 2, "t6_identity_a2");
        expect_val(1, 0, 7, "t6_identity_a7");

        step(); step();
        if (q.size() != 0) begin
            n_cmp++; n_mis++;
            $display("FAIL queue_drain: %0d left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rat_rename_map.md
Name: rat_rename_map

Overview:
- Speculative register alias table (front-end RAT) that pairs with the retirement RAT.
- Renames up to SCALAR instructions per cycle: source lookup, destination allocation, and old-mapping output for the ROB.
- On rollback, restores the whole table from the retirement RAT's committed map, then holds rename stalled for a fixed recovery window.

Parameters:
- SCALAR, 2, rename slots per cycle (slot 0 is oldest).
- NUM_ENTRIES, 32, architectural registers / table entries.
- AREG_IDX_WIDTH, 5, architectural index width (log2 NUM_ENTRIES).
- PREG_IDX_WIDTH, 6, physical tag width.
- RECOVER_CYCLES, 2, stall cycles after a rollback restore (>=1).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; 0 resets on the posedge.
- rename_en  in  SCALAR  per-slot valid rename request.
- src1_areg  in  SCALAR*AREG_IDX_WIDTH  per-slot source 1 architectural index.
- src2_areg  in  SCALAR*AREG_IDX_WIDTH  per-slot source 2 architectural index.
- dest_areg  in  SCALAR*AREG_IDX_WIDTH  per-slot destination architectural index.
- dest_preg  in  SCALAR*PREG_IDX_WIDTH  new tag from the freelist, per slot.
- rollback_en  in  1  squash request; restore from rrat_map_in.
- rrat_map_in  in  NUM_ENTRIES*PREG_IDX_WIDTH  committed map from the retirement RAT; entry i in bits [i*P +: P].
- src1_preg  out  SCALAR*PREG_IDX_WIDTH  renamed source 1 tag.
- src2_preg  out  SCALAR*PREG_IDX_WIDTH  renamed source 2 tag.
- old_dest_preg  out  SCALAR*PREG_IDX_WIDTH  previous mapping of dest_areg, sent to the ROB for freeing at retire.
- rename_stall  out  1  high while recovering; rename requests are ignored.

Behaviour:
- Storage: map[NUM_ENTRIES] of PREG_IDX_WIDTH bits.
- Reset (reset==0 at posedge):
  - map[i] = i.
  - State = NORMAL; recovery counter = 0.
  - Registered outputs: none. Lookup outputs are combinational from the map, so they read identity after reset; rename_stall = 0.
- Lookups are combinational, same cycle as rename_en.
  - srcN_preg = map[srcN_areg], with intra-group bypass.
  - For slot k, if an older slot j<k has rename_en, dest_areg!=0 and dest_areg == srcN_areg, return dest_preg of the youngest such j.
  - old_dest_preg uses the same bypass rule against dest_areg.
  - Outputs are don't-care when rename_en=0 or stalled; the bench checks them only when valid.
- Writes, on posedge in NORMAL with no rollback_en:
  - For each slot with rename_en=1 and dest_areg!=0: map[dest_areg] <= dest_preg.
  - If multiple slots share a dest_areg, the youngest (highest index) wins.
- Areg 0 is hardwired: never written, always reads map[0] (preg 0 after reset/restore if the RRAT holds 0).
- FSM has states NORMAL and RECOVER.
  - NORMAL, rollback_en=1: map <= rrat_map_in (all entries, same edge); counter <= RECOVER_CYCLES-1; state <= RECOVER. Any rename_en in that cycle is dropped.
  - RECOVER: rename_stall=1 and rename writes are ignored. Counter decrements each cycle; when counter==0, state <= NORMAL.
  - rollback_en=1 during RECOVER: reload map from rrat_map_in and restart the counter at RECOVER_CYCLES-1.
  - rename_stall is combinational on state: high in RECOVER, and also high in NORMAL during a cycle with rollback_en=1.
- Reset dominates everything, including mid-RECOVER: identity map, NORMAL.
- The block never backpressures in NORMAL; the freelist guarantees dest_preg availability.

Optional Feature:
- Macro RAT_RECOVER_BYPASS_EN.
- When defined:
  - RECOVER state and counter are removed.
  - Rollback restores the map on the edge and rename resumes the next cycle.
  - rename_stall is high only in the cycle with rollback_en=1.
  - RECOVER_CYCLES is ignored.
- When undefined: behaviour as specified above.

Test Plan:
1. Reset, then no writes -> src1_areg=5 returns src1_preg=5; src2_areg=31 returns 31.
2. Slot0 dest 3->preg 40, slot1 dest 4->preg 41, same cycle -> next cycle src1_areg=3 returns 40 and src2_areg=4 returns 41; old_dest_preg for areg 3 = 3.
3. Bypass: slot0 dest 7->preg 50, slot1 src1_areg=7, dest 7->preg 51, same cycle -> slot1 src1_preg=50, slot1 old_dest_preg=50; next cycle map[7]=51.
4. Dest areg 0 with preg 60 -> map[0] stays 0; a following src1_areg=0 returns 0.
5. rrat_map_in entry i = i+32; rollback_en pulse with a concurrent rename of areg 2->preg 45 -> map[2]=34 (rename dropped); rename_stall high in the rollback cycle plus 2 cycles, low after.
6. reset=0 during RECOVER -> next cycle rename_stall=0 and map is identity (src1_areg=2 returns 2).
